// File: rtl/fft_frame_ctrl.sv
// Stream sequencer around the 4096-point FFT core: gates the core clock enable, frames results as a
// valid/ready stream with bin markers, and flushes/drains. FFT_FRAME_CTRL_STALL_CNT_EN adds o_stall_cnt.
module fft_frame_ctrl #(
    parameter int LGSIZE = 12,
    parameter int IW     = 12,
    parameter int OW     = 19,
    parameter int FCW    = 3
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_s_valid,
    output logic                o_s_ready,
    input  logic [2*IW-1:0]     i_s_data,
    input  logic                i_flush,
    output logic                o_fft_reset,
    output logic                o_fft_ce,
    output logic [2*IW-1:0]     o_fft_sample,
    input  logic [2*OW-1:0]     i_fft_result,
    input  logic                i_fft_sync,
    output logic                o_m_valid,
    input  logic                i_m_ready,
    output logic [2*OW-1:0]     o_m_data,
    output logic [LGSIZE-1:0]   o_m_bin,
    output logic                o_m_first,
    output logic                o_m_last,
    output logic                o_busy
`ifdef FFT_FRAME_CTRL_STALL_CNT_EN
    ,
    output logic [15:0]         o_stall_cnt
`endif
);

    typedef enum logic [1:0] {S_RUN, S_PAD, S_DRAIN, S_CLR} state_t;

    localparam logic [LGSIZE-1:0] LAST_BIN = {LGSIZE{1'b1}};

    state_t              state_q, state_d;
    logic [LGSIZE-1:0]   in_idx_q, in_idx_d;
    logic [LGSIZE-1:0]   bin_q, bin_d;
    logic [FCW-1:0]      inflight_q, inflight_d;
    logic                started_q, started_d;
    logic                pend_q, pend_d;
    logic                room, feeding, counting, hs, wrap, dec;

    always_comb begin
        o_m_valid    = pend_q && (started_q || i_fft_sync) && (inflight_q != '0);
        room         = !o_m_valid || i_m_ready;
        feeding      = (state_q == S_PAD) || (state_q == S_DRAIN);
        counting     = (state_q == S_RUN) || (state_q == S_PAD);
        o_fft_ce     = room && ((state_q == S_RUN) ? i_s_valid : feeding);
        o_s_ready    = (state_q == S_RUN) && room;
        o_fft_sample = (state_q == S_RUN) ? i_s_data : '0;
        o_fft_reset  = i_reset || (state_q == S_CLR);
        o_m_data     = i_fft_result;
        // The core flags bin 0 with sync; realign the local bin counter on it.
        o_m_bin      = (o_m_valid && i_fft_sync) ? '0 : bin_q;
        o_m_first    = (o_m_bin == '0);
        o_m_last     = (o_m_bin == LAST_BIN);
        o_busy       = (state_q != S_RUN) || (inflight_q != '0);
        hs           = o_m_valid && i_m_ready;
        wrap         = o_fft_ce && counting && (in_idx_q == LAST_BIN);
        dec          = hs && o_m_last;
    end

    always_comb begin
        state_d    = state_q;
        in_idx_d   = in_idx_q;
        bin_d      = bin_q;
        inflight_d = inflight_q;
        started_d  = started_q;
        pend_d     = pend_q;

        if (o_fft_ce && counting)
            in_idx_d = in_idx_q + 1'b1;

        if (wrap && !dec)
            inflight_d = inflight_q + 1'b1;
        else if (dec && !wrap)
            inflight_d = inflight_q - 1'b1;

        // A core output not accepted as a beat (pre-sync or no frame in flight) is dropped.
        if (o_fft_ce)
            pend_d = 1'b1;
        else if (hs || (pend_q && !o_m_valid))
            pend_d = 1'b0;

        if (pend_q && i_fft_sync)
            started_d = 1'b1;

        if (hs)
            bin_d = o_m_bin + 1'b1;

        case (state_q)
            S_RUN: begin
                if (i_flush) begin
                    if (in_idx_q != '0)
                        state_d = S_PAD;
                    else if (inflight_q != '0)
                        state_d = S_DRAIN;
                end
            end
            S_PAD: begin
                if (wrap)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (dec && (inflight_q == FCW'(1)))
                    state_d = S_CLR;
            end
            S_CLR: begin
                state_d   = S_RUN;
                in_idx_d  = '0;
                bin_d     = '0;
                started_d = 1'b0;
                pend_d    = 1'b0;
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_RUN;
            in_idx_q   <= '0;
            bin_q      <= '0;
            inflight_q <= '0;
            started_q  <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_idx_q   <= in_idx_d;
            bin_q      <= bin_d;
            inflight_q <= inflight_d;
            started_q  <= started_d;
            pend_q     <= pend_d;
        end
    end

`ifdef FFT_FRAME_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == S_CLR)
            stall_cnt_d = '0;
        else if (o_m_valid && !i_m_ready && (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            stall_cnt_q <= '0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl. The FFT core is modelled as a ce-counting pipe of latency N+3
// whose result word equals its output sample index, so every bin's expected data and index are known.
module tb_fft_frame_ctrl;
    localparam int LGSIZE = 12;
    localparam int IW     = 12;
    localparam int OW     = 19;
    localparam int FCW    = 3;
    localparam int N      = 1 << LGSIZE;
    localparam logic [31:0] N_U = 32'(N);
    localparam logic [31:0] LAT = 32'(N + 3);

    logic                clk = 1'b0;
    logic                i_reset, i_s_valid, o_s_ready, i_flush;
    logic [2*IW-1:0]     i_s_data, o_fft_sample;
    logic                o_fft_reset, o_fft_ce, i_fft_sync;
    logic [2*OW-1:0]     i_fft_result, o_m_data;
    logic                o_m_valid, i_m_ready, o_m_first, o_m_last, o_busy;
    logic [LGSIZE-1:0]   o_m_bin;
`ifdef FFT_FRAME_CTRL_STALL_CNT_EN
    logic [15:0]         o_stall_cnt;
`endif

    int total = 0;
    int bad = 0;
    int exp_j, ce_pulses, rst_pulses, stalls, gaps;
    bit seen_valid, gap_chk, took;
    logic [31:0] core_cnt;

    always #5 clk = ~clk;

    fft_frame_ctrl #(.LGSIZE(LGSIZE), .IW(IW), .OW(OW), .FCW(FCW)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_s_valid(i_s_valid), .o_s_ready(o_s_ready),
        .i_s_data(i_s_data), .i_flush(i_flush), .o_fft_reset(o_fft_reset), .o_fft_ce(o_fft_ce),
        .o_fft_sample(o_fft_sample), .i_fft_result(i_fft_result), .i_fft_sync(i_fft_sync),
        .o_m_valid(o_m_valid), .i_m_ready(i_m_ready), .o_m_data(o_m_data), .o_m_bin(o_m_bin),
        .o_m_first(o_m_first), .o_m_last(o_m_last), .o_busy(o_busy)
`ifdef FFT_FRAME_CTRL_STALL_CNT_EN
        , .o_stall_cnt(o_stall_cnt)
`endif
    );

    // Core model: output advances only on ce and holds otherwise.
    always @(posedge clk) begin
        if (o_fft_reset)
            core_cnt <= '0;
        else if (o_fft_ce)
            core_cnt <= core_cnt + 1;
    end
    assign i_fft_sync   = (core_cnt >= LAT) && (((core_cnt - LAT) & (N_U - 1)) == '0);
    assign i_fft_result = (core_cnt >= LAT) ? (2*OW)'(core_cnt - LAT) : {2*OW{1'b1}};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample everything at the falling edge, then return just after the rising edge.
    task automatic cyc(output bit acc);
        @(negedge clk);
        acc = o_s_ready && i_s_valid;
        if (o_m_valid) begin
            check("m_data", o_m_data, exp_j);
            check("m_bin", o_m_bin, exp_j % N);
            check("m_first", o_m_first, (exp_j % N) == 0);
            check("m_last", o_m_last, (exp_j % N) == N - 1);
            seen_valid = 1'b1;
        end else if (gap_chk && seen_valid) begin
            gaps++;
        end
        if (o_m_valid && !i_m_ready) begin
            stalls++;
            check("stall_s_ready", o_s_ready, 0);
            check("stall_ce", o_fft_ce, 0);
        end
        if (o_s_ready)
            check("ce_eq_hs", o_fft_ce, i_s_valid);
        if (acc)
            check("sample_pass", o_fft_sample, i_s_data);
        else if (o_fft_ce)
            check("sample_zero", o_fft_sample, 0);
        if (o_fft_ce)
            ce_pulses++;
        if (o_fft_reset)
            rst_pulses++;
        if (o_m_valid && i_m_ready)
            exp_j++;
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int n, input int vpct, input int rpct);
        int acc_n = 0;
        int cycles = 0;
        bit acc;
        while (acc_n < n && cycles < 8 * n + 100) begin
            i_s_valid = ($urandom_range(99) < vpct);
            i_s_data  = (2*IW)'(acc_n * 37 + 5);
            i_m_ready = ($urandom_range(99) < rpct);
            cyc(acc);
            if (acc)
                acc_n++;
            cycles++;
        end
        i_s_valid = 1'b0;
        check("feed_accepted", acc_n, n);
    endtask

    task automatic drain(input int rpct);
        int cycles = 0;
        bit acc;
        rst_pulses = 0;
        i_s_valid  = 1'b0;
        i_flush    = 1'b1;
        i_m_ready  = ($urandom_range(99) < rpct);
        cyc(acc);
        i_flush = 1'b0;
        check("busy_after_flush", o_busy, 1);
        while (o_busy && cycles < 6 * N) begin
            i_m_ready = ($urandom_range(99) < rpct);
            cyc(acc);
            cycles++;
        end
        check("drain_done", o_busy, 0);
        check("fft_reset_pulses", rst_pulses, 1);
    endtask

    initial begin
        i_reset = 1'b1; i_s_valid = 1'b0; i_s_data = '0; i_flush = 1'b0; i_m_ready = 1'b1;
        exp_j = 0; ce_pulses = 0; rst_pulses = 0; stalls = 0; gaps = 0;
        seen_valid = 1'b0; gap_chk = 1'b0;

        // Reset state
        repeat (3) cyc(took);
        check("rst_fft_reset", o_fft_reset, 1);
        check("rst_valid", o_m_valid, 0);
        check("rst_ce", o_fft_ce, 0);
        i_reset = 1'b0;
        cyc(took);
        check("post_rst_busy", o_busy, 0);
        check("post_rst_fft_reset", o_fft_reset, 0);
        check("post_rst_s_ready", o_s_ready, 1);
        check("post_rst_bin", o_m_bin, 0);

        // Flush with nothing in flight is a no-op
        ce_pulses = 0; rst_pulses = 0;
        i_flush = 1'b1;
        cyc(took);
        i_flush = 1'b0;
        cyc(took);
        check("noop_flush_ce", ce_pulses, 0);
        check("noop_flush_busy", o_busy, 0);
        check("noop_flush_reset", rst_pulses, 0);
        check("noop_flush_s_ready", o_s_ready, 1);

        // Three back-to-back frames, always ready
        exp_j = 0; ce_pulses = 0; gaps = 0; seen_valid = 1'b0; gap_chk = 1'b1;
        feed(3 * N, 100, 100);
        gap_chk = 1'b0;
        check("s1_seen_valid", seen_valid, 1);
        check("s1_gaps", gaps, 0);
        check("s1_ce_pulses", ce_pulses, 3 * N);
        drain(100);
        check("s1_beats", exp_j, 3 * N);

        // Random downstream backpressure over two frames
        exp_j = 0; stalls = 0;
        feed(2 * N, 100, 50);
        check("s2_stalls_seen", stalls > 0, 1);
`ifdef FFT_FRAME_CTRL_STALL_CNT_EN
        check("s2_stall_cnt", o_stall_cnt, stalls);
`endif
        drain(50);
        check("s2_beats", exp_j, 2 * N);
`ifdef FFT_FRAME_CTRL_STALL_CNT_EN
        check("s2_stall_cnt_clr", o_stall_cnt, 0);
`endif

        // Random input gaps: one ce per accepted sample
        exp_j = 0; ce_pulses = 0;
        feed(2 * N, 70, 100);
        check("s3_ce_pulses", ce_pulses, 2 * N);
        drain(100);
        check("s3_beats", exp_j, 2 * N);

        // Partial frame: pad 3096 zeros, then run the core until frame 0 drains
        exp_j = 0;
        feed(1000, 100, 100);
        ce_pulses = 0;
        drain(100);
        check("s4_flush_ce_pulses", ce_pulses, 2 * N + 3 - 1000);
        check("s4_beats", exp_j, N);

        // Reset in the middle of a drain, then a clean frame
        exp_j = 0;
        feed(N, 100, 100);
        i_flush = 1'b1;
        cyc(took);
        i_flush = 1'b0;
        repeat (200) cyc(took);
        check("s6_busy_draining", o_busy, 1);
        i_reset = 1'b1;
        cyc(took);
        check("s6_fft_reset", o_fft_reset, 1);
        i_reset = 1'b0;
        check("s6_valid_after_rst", o_m_valid, 0);
        check("s6_busy_after_rst", o_busy, 0);
        check("s6_s_ready_after_rst", o_s_ready, 1);
        exp_j = 0;
        feed(N, 100, 100);
        drain(100);
        check("s6_beats", exp_j, N);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft_frame_ctrl.md
Name: fft_frame_ctrl

Overview:
Streaming front/back-end sequencer for the 4096-point single-sample-per-clock FFT core (fftmain).
- Converts a valid/ready sample stream into the core's clock-enable, and frames the core's outputs as a valid/ready stream with bin index and first/last markers.
- Handles downstream backpressure by stalling the core, and provides a flush that zero-pads a partial frame, drains every in-flight frame, then resets the core.

Parameters:
LGSIZE, 12, log2 of FFT length; frame length N = 2**LGSIZE.
IW, 12, input component width; sample is 2*IW bits, real part in the high half.
OW, 19, output component width; result is 2*OW bits.
FCW, 3, width of the in-flight frame counter.

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_s_valid  in  1  input sample valid
o_s_ready  out  1  input sample accepted when high with i_s_valid
i_s_data  in  2*IW  input complex sample
i_flush  in  1  flush request; sampled in S_RUN only
o_fft_reset  out  1  drive core i_reset
o_fft_ce  out  1  drive core i_clk_enable
o_fft_sample  out  2*IW  drive core i_sample
i_fft_result  in  2*OW  core o_result
i_fft_sync  in  1  core o_sync
o_m_valid  out  1  output bin valid
i_m_ready  in  1  downstream accept
o_m_data  out  2*OW  output bin, equal to i_fft_result
o_m_bin  out  LGSIZE  bin index of o_m_data, in bit-reversal-corrected order
o_m_first  out  1  high when o_m_bin==0
o_m_last  out  1  high when o_m_bin==N-1
o_busy  out  1  high when state!=S_RUN or inflight!=0

Behaviour:
Clock and reset
- Clock is i_clk. Reset is i_reset: synchronous, active-high.
- Reset state is S_RUN. in_idx, o_m_bin, inflight, started and pend are all 0.
- Outputs after reset: o_m_valid=0, o_fft_ce=0, o_busy=0. o_fft_reset=1 while i_reset is high.

Clock-enable gating
- room = !o_m_valid || i_m_ready.
- o_fft_ce = room && (S_RUN ? i_s_valid : S_PAD||S_DRAIN).
- o_s_ready = S_RUN && room. In S_RUN, o_fft_ce equals the input handshake.
- o_fft_sample = i_s_data in S_RUN, 0 otherwise.

Input side
- in_idx increments on each o_fft_ce in S_RUN/S_PAD and wraps N-1 -> 0.
- A wrap increments inflight.

Output side
- pend <= o_fft_ce ? 1 : (handshake or discard ? 0 : pend).
- started sets on the first cycle pend && i_fft_sync; cleared only by reset or S_CLR.
- o_m_valid = pend && (started || i_fft_sync) && inflight!=0.
- pend && !o_m_valid is a discard: pend clears next cycle.
- o_m_data is combinational from i_fft_result. The core holds its output while ce is low, so the data is stable under stall.
- o_m_bin: forced to 0 on a valid beat with i_fft_sync; otherwise increments per handshake.
- A handshake with o_m_last decrements inflight.
- A simultaneous increment and decrement leaves inflight unchanged.
- inflight never exceeds 2**FCW-1. Upstream cannot exceed this because core latency is about 2N.

State machine
- S_RUN: i_flush && in_idx!=0 -> S_PAD. i_flush && in_idx==0 && inflight!=0 -> S_DRAIN. i_flush with nothing in flight -> stay in S_RUN (no-op).
- S_PAD: feeds zeros until in_idx wraps (frame counted) -> S_DRAIN.
- S_DRAIN: feeds zeros until the handshake that decrements inflight to 0 -> S_CLR.
- S_CLR: one cycle; o_fft_reset=1; in_idx, o_m_bin, started and pend are cleared -> S_RUN.
- i_flush is ignored outside S_RUN.
- i_reset mid-operation aborts any state immediately; the core is reset in the same cycle.

Optional Feature:
Macro FFT_FRAME_CTRL_STALL_CNT_EN.
- Defined: adds port o_stall_cnt, output, 16 bits. It counts cycles with o_m_valid && !i_m_ready, saturates at 16'hFFFF, and is cleared by i_reset or S_CLR.
- Undefined: port and logic absent.

Test Plan:
1. Continuous valid, ready=1, 3 frames of an impulse at sample 0 -> three 4096-beat output frames, every bin equal. o_m_first at bin 0, o_m_last at 4095, no gaps after the first valid beat.
2. Random i_m_ready at 50% over 2 frames of a tone in bin 100 -> peak at o_m_bin==100. o_m_data stable while stalled, o_s_ready==0 on stalled cycles, no lost or duplicated bins. With the macro defined, o_stall_cnt equals the counted stall cycles.
3. Random i_s_valid gaps at 30% -> output identical to scenario 1 apart from timing; o_fft_ce pulses == accepted samples.
4. 1000 samples then i_flush -> S_PAD feeds 3096 zeros, exactly one output frame with last at bin 4095. Then a single-cycle o_fft_reset, and o_busy falls to 0.
5. i_flush with inflight=0 and in_idx=0 -> no state change, no o_fft_ce, o_busy stays 0.
6. i_reset asserted during S_DRAIN -> next cycle o_m_valid=0 and state S_RUN. A new 4096-sample frame is then processed correctly with bin 0 first.
